dili_reduce_pipe: RTL and testbench
===================================

DILI_REDUCE_PIPE -- requirements
Module: dili_reduce_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, signed coefficient width per lane (legal range 32..48).
REQ-002 SHALL have parameter LANES, default 4, number of coefficients processed in parallel (legal range 1..16).
REQ-003 SHALL have parameter Q, default 8380417, modulus.
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset: synchronous and active-high.
REQ-006 SHALL have port mode_i, input, 2, operation select, sampled with each accepted beat: 00 reduce32, 01 caddq, 10 freeze, 11 pass.
REQ-007 SHALL have port in_valid_i, input, 1, input beat valid.
REQ-008 SHALL have port in_ready_o, output, 1, block can accept a beat.
REQ-009 SHALL have port a_i, input, LANES*WIDTH, signed coefficients; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid_o, output, 1, result beat valid.
REQ-011 SHALL have port out_ready_i, input, 1, downstream accepts the beat.
REQ-012 SHALL have port r_o, output, LANES*WIDTH, signed results, same lane packing as a_i.
REQ-013 SHALL have port cnt_o, output, 16, count of completed output beats (see Configuration).

Function
REQ-014 reduce32 SHALL compute t = (a + 2^22) >>> 23 and r = a - t*Q; the sum SHALL be formed at WIDTH+1 bits so that it never overflows.
REQ-015 caddq SHALL compute r = a + Q if a < 0, else r = a.
REQ-016 freeze SHALL compute caddq(reduce32(a)); its result lies in [0, Q-1] for every WIDTH=32 input.
REQ-017 pass SHALL return r = a unchanged.
REQ-018 All lanes SHALL apply the same mode; there SHALL be no cross-lane dependency.
REQ-019 Pipeline SHALL be 2 register stages: S1 registers t, a and mode; S2 registers r.
REQ-020 Latency SHALL be exactly 2 cycles from the accept edge to out_valid_o, absent backpressure.
REQ-021 A beat SHALL be accepted on any edge where in_valid_i && in_ready_o; it SHALL transfer out on any edge where out_valid_o && out_ready_i.
REQ-022 in_ready_o SHALL equal !S2_valid || out_ready_i || !S1_valid, and SHALL be combinational with no dependency on in_valid_i.
REQ-023 The pipeline SHALL sustain throughput of 1 beat per cycle while out_ready_i stays high.
REQ-024 While out_ready_i is low with S2 full, S2 SHALL hold r_o stable, and S1 SHALL hold if it is full.
REQ-025 r_o and out_valid_o SHALL NOT change while out_valid_o && !out_ready_i.
REQ-026 Simultaneous accept and output transfer SHALL advance all stages in the same edge, with no beat lost or duplicated.
REQ-027 When a stage is empty, its data registers SHALL hold their previous value; r_o is don't-care while out_valid_o = 0.

Reset
REQ-028 When rst_i is high at an edge, S1_valid, S2_valid and cnt_o SHALL clear to 0 and r_o SHALL clear to 0.
REQ-029 Reset mid-operation SHALL discard every in-flight beat; the first beat accepted after reset SHALL be numbered from scratch.
REQ-030 in_ready_o SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-031 Macro DILI_REDUCE_CNT_EN defined: cnt_o SHALL increment by 1 on each output transfer and SHALL wrap 0xFFFF -> 0x0000.
REQ-032 Macro DILI_REDUCE_CNT_EN undefined: cnt_o SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-033 Q, the 2^22 rounding constant, the shift value 23 and the mode enum (MODE_REDUCE32, MODE_CADDQ, MODE_FREEZE, MODE_PASS) SHALL live in shared package dili_pkg.
REQ-034 Per-lane arithmetic SHALL live in sub-module dili_reduce_lane, which takes a, mode and the S1 register and returns r; it SHALL be instantiated LANES times via generate.
REQ-035 Handshake and counter SHALL reside in dili_reduce_pipe only.

Verification
REQ-036 reduce32, lane inputs {8380417, -1, 2147483647, -2147483648} -> r_o {0, -1, 2096895, -2096896} after 2 cycles.
REQ-037 caddq with -1 -> 8380416; freeze with -1 -> 8380416; freeze with 8380417 -> 0; pass with -5 -> -5.
REQ-038 100 back-to-back beats with random out_ready_i -> output order and values match the reference model; no drop, no duplicate; r_o stable while stalled.
REQ-039 Two beats accepted, then rst_i pulsed for 1 cycle -> out_valid_o = 0, cnt_o = 0, and no stale beat appears afterwards.
REQ-040 With DILI_REDUCE_CNT_EN, 65537 transfers -> cnt_o = 1; without DILI_REDUCE_CNT_EN, cnt_o = 0 throughout.
REQ-041 LANES = 1 and LANES = 16 builds pass REQ-036 on every lane.

Source files
------------

// File: rtl/dili_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dili_pkg
// Description : Shared constants and operation-mode encoding for the reduction pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package dili_pkg;

    localparam int C_DILI_Q = 8380417;
    localparam int C_RND    = 1 << 22;
    localparam int C_SHIFT  = 23;

    typedef enum logic [1:0] {
        MODE_REDUCE32 = 2'b00,
        MODE_CADDQ    = 2'b01,
        MODE_FREEZE   = 2'b10,
        MODE_PASS     = 2'b11
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/dili_reduce_lane.sv
`default_nettype none
// ============================================================================
// Module      : dili_reduce_lane
// Description : One-lane arithmetic: quotient estimate t from raw a, and the
//               final result r from the registered S1 values.
// Revision    : 1.0 - initial release
// ============================================================================
module dili_reduce_lane
    import dili_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int Q     = C_DILI_Q
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] t_o,
    input  logic [WIDTH-1:0] s1_a_i,
    input  logic [WIDTH-1:0] s1_t_i,
    input  mode_e            s1_mode_i,
    output logic [WIDTH-1:0] r_o
);

    localparam logic signed [WIDTH-1:0] C_QW    = WIDTH'(Q);
    localparam logic signed [WIDTH:0]   C_RND_W = (WIDTH+1)'(C_RND);

    logic signed [WIDTH:0]   w_sum;
    logic signed [WIDTH:0]   w_sh;
    logic                    w_unused_msb;
    logic signed [WIDTH-1:0] w_red;

    // One extra bit keeps a + 2^22 from wrapping at the positive extreme.
    assign w_sum        = $signed({a_i[WIDTH-1], a_i}) + C_RND_W;
    assign w_sh         = w_sum >>> C_SHIFT;
    assign t_o          = w_sh[WIDTH-1:0];
    assign w_unused_msb = w_sh[WIDTH];

    assign w_red = $signed(s1_a_i) - $signed(s1_t_i) * C_QW;

    function automatic logic [WIDTH-1:0] caddq(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? x + C_QW : x;
    endfunction

    always_comb begin
        r_o = s1_a_i;
        case (s1_mode_i)
            MODE_REDUCE32: r_o = w_red;
            MODE_CADDQ:    r_o = caddq($signed(s1_a_i));
            MODE_FREEZE:   r_o = caddq(w_red);
            default:       r_o = s1_a_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dili_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dili_reduce_pipe
// Description : Two-stage valid/ready pipe applying reduce32/caddq/freeze/pass
//               across LANES coefficients. Define DILI_REDUCE_CNT_EN to enable
//               the output-beat counter on cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module dili_reduce_pipe
    import dili_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int Q     = C_DILI_Q
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             mode_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES*WIDTH-1:0] a_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES*WIDTH-1:0] r_o,
    output logic [15:0]            cnt_o
);

    localparam int C_LW = LANES * WIDTH;

    logic            s1_valid_q;
    logic            s2_valid_q;
    logic [C_LW-1:0] s1_a_q;
    logic [C_LW-1:0] s1_t_q;
    mode_e           s1_mode_q;
    logic [C_LW-1:0] r_q;
    logic [C_LW-1:0] t_d;
    logic [C_LW-1:0] r_d;
    logic            w_s2_free;
    logic            w_accept;

    assign w_s2_free   = !s2_valid_q || out_ready_i;
    assign in_ready_o  = !s2_valid_q || out_ready_i || !s1_valid_q;
    assign w_accept    = in_valid_i && in_ready_o;
    assign out_valid_o = s2_valid_q;
    assign r_o         = r_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            r_q        <= '0;
        end else begin
            if (w_s2_free) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    r_q <= r_d;
                end
            end
            if (in_ready_o) begin
                s1_valid_q <= in_valid_i;
            end
        end
    end

    // S1 data only moves on an accepted beat; empty stages keep stale contents.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            s1_a_q    <= a_i;
            s1_t_q    <= t_d;
            s1_mode_q <= mode_e'(mode_i);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dili_reduce_lane #(
            .WIDTH (WIDTH),
            .Q     (Q)
        ) u_lane (
            .a_i       (a_i[k*WIDTH +: WIDTH]),
            .t_o       (t_d[k*WIDTH +: WIDTH]),
            .s1_a_i    (s1_a_q[k*WIDTH +: WIDTH]),
            .s1_t_i    (s1_t_q[k*WIDTH +: WIDTH]),
            .s1_mode_i (s1_mode_q),
            .r_o       (r_d[k*WIDTH +: WIDTH])
        );
    end

`ifdef DILI_REDUCE_CNT_EN
    logic [15:0] cnt_q;
    logic        w_xfer;

    assign w_xfer = s2_valid_q && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (w_xfer) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dili_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dili_reduce_pipe
// Description : Self-checking bench for dili_reduce_pipe (WIDTH=32, LANES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dili_reduce_pipe;

    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int LW    = WIDTH * LANES;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] a;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] r;
    logic [15:0]   cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_exp = 0;

    always #5 clk = ~clk;

    dili_reduce_pipe #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .Q     (8380417)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .r_o         (r),
        .cnt_o       (cnt)
    );

    typedef struct {
        logic [1:0]    m;
        logic [LW-1:0] a;
        logic [LW-1:0] e;
    } vec_t;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cnt_req();
`ifdef DILI_REDUCE_CNT_EN
        return 16'(cnt_exp);
`else
        return 16'd0;
`endif
    endfunction

    // Reference straight from the arithmetic definition, done in 64-bit integers.
    function automatic logic [31:0] ref_lane(input logic [1:0] m, input logic [31:0] x);
        longint av, t, red, res;
        av  = longint'($signed(x));
        t   = (av + 64'sd4194304) >>> 23;
        red = av - t * 64'sd8380417;
        case (m)
            2'd0:    res = red;
            2'd1:    res = (av < 0) ? av + 64'sd8380417 : av;
            2'd2:    res = (red < 0) ? red + 64'sd8380417 : red;
            default: res = av;
        endcase
        return res[31:0];
    endfunction

    function automatic logic [LW-1:0] ref_vec(input logic [1:0] m, input logic [LW-1:0] x);
        logic [LW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*WIDTH +: WIDTH] = ref_lane(m, x[k*WIDTH +: WIDTH]);
        return v;
    endfunction

    function automatic logic [31:0] rand_coef();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            2:       v = 32'($urandom_range(0, 1) ? 4194304 : -4194304) + 32'($urandom_range(0, 8)) - 32'd4;
            default: v = 32'($urandom_range(0, 16760834)) - 32'd8380417;
        endcase
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_vec();
        logic [LW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*WIDTH +: WIDTH] = rand_coef();
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cnt_exp = 0;
    endtask

    vec_t vecs[5];

    initial begin
        logic [LW-1:0] q[$];
        logic [LW-1:0] exp_thru[8];
        logic [LW-1:0] cur_a;
        logic [LW-1:0] hold_r;
        logic [1:0]    cur_m;
        logic          hold_v;
        int            sent, recv, cyc;

        vecs[0] = '{2'd0, {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd8380417},
                          {32'hFFE0_0100, 32'h001F_FEFF, 32'hFFFF_FFFF, 32'h0000_0000}};
        vecs[1] = '{2'd1, {32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000, 32'hFF80_1FFF},
                          {32'h007F_E000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000}};
        vecs[2] = '{2'd2, {32'hFFFF_FFFF, 32'd8380417, 32'h7FFF_FFFF, 32'h8000_0000},
                          {32'h007F_E000, 32'h0000_0000, 32'h001F_FEFF, 32'h005F_E101}};
        vecs[3] = '{2'd3, {32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678},
                          {32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678}};
        vecs[4] = '{2'd0, {32'h0040_0000, 32'h003F_FFFF, 32'hFFC0_0000, 32'hFFBF_FFFF},
                          {32'hFFC0_1FFF, 32'h003F_FFFF, 32'hFFC0_0000, 32'h003F_E000}};

        rst = 1'b1; mode = 2'd0; in_valid = 1'b0; a = '0; out_ready = 1'b0;
        @(negedge clk);
        do_reset();
        #1;
        check("reset_out_valid", LW'(out_valid), LW'(1'b0));
        check("reset_r", r, '0);
        check("reset_cnt", LW'(cnt), '0);
        check("reset_in_ready", LW'(in_ready), LW'(1'b1));
        @(negedge clk);

        // Directed table: 2-cycle latency and exact values.
        foreach (vecs[i]) begin
            in_valid = 1'b1; mode = vecs[i].m; a = vecs[i].a; out_ready = 1'b1;
            #1;
            check("tbl_in_ready", LW'(in_ready), LW'(1'b1));
            step();
            in_valid = 1'b0;
            #1;
            check("tbl_lat1_not_valid", LW'(out_valid), LW'(1'b0));
            step();
            #1;
            check("tbl_lat2_valid", LW'(out_valid), LW'(1'b1));
            check($sformatf("tbl_r[%0d]", i), r, vecs[i].e);
            cnt_exp++;
            step();
        end
        #1;
        check("tbl_cnt", LW'(cnt), LW'(cnt_req()));
        @(negedge clk);

        // Back-to-back throughput with downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; mode = 2'($urandom_range(0, 3)); a = rand_vec();
                exp_thru[i] = ref_vec(mode, a);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 8) check("thru_in_ready", LW'(in_ready), LW'(1'b1));
            if (i >= 2) begin
                check("thru_valid", LW'(out_valid), LW'(1'b1));
                check("thru_r", r, exp_thru[i-2]);
                cnt_exp++;
            end
            step();
        end

        // Random stimulus with random backpressure against the reference queue.
        sent = 0; recv = 0; cyc = 0; hold_v = 1'b0; hold_r = '0;
        cur_a = rand_vec(); cur_m = 2'($urandom_range(0, 3));
        while (recv < 100 && cyc < 3000) begin
            in_valid  = (sent < 100);
            a         = cur_a;
            mode      = cur_m;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (hold_v) begin
                check("stall_valid", LW'(out_valid), LW'(1'b1));
                check("stall_r", r, hold_r);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious_beat", LW'(1'b1), LW'(1'b0));
                end else begin
                    check("rand_beat", r, q.pop_front());
                end
                recv++;
                cnt_exp++;
            end
            hold_v = out_valid && !out_ready;
            hold_r = r;
            if (in_valid && in_ready) begin
                q.push_back(ref_vec(cur_m, cur_a));
                sent++;
                cur_a = rand_vec();
                cur_m = 2'($urandom_range(0, 3));
            end
            step();
            cyc++;
        end
        if (recv < 100) check("rand_timeout", LW'(recv), LW'(100));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rand_no_duplicate", LW'(out_valid), LW'(1'b0));
            step();
        end
        #1;
        check("rand_cnt", LW'(cnt), LW'(cnt_req()));
        @(negedge clk);

        // Reset with two beats in flight and downstream stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; mode = 2'd3; a = rand_vec();
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt_exp = 0;
        #1;
        check("rst_out_valid", LW'(out_valid), LW'(1'b0));
        check("rst_cnt", LW'(cnt), '0);
        check("rst_r", r, '0);
        check("rst_in_ready", LW'(in_ready), LW'(1'b1));
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rst_no_stale", LW'(out_valid), LW'(1'b0));
            step();
        end
        in_valid = 1'b1; mode = 2'd2; a = vecs[2].a;
        step();
        in_valid = 1'b0;
        step();
        #1;
        check("rst_first_valid", LW'(out_valid), LW'(1'b1));
        check("rst_first_r", r, vecs[2].e);
        cnt_exp++;
        step();
        #1;
        check("rst_first_cnt", LW'(cnt), LW'(cnt_req()));
        @(negedge clk);

`ifdef DILI_REDUCE_CNT_EN
        // Counter wrap: 65537 transfers from a fresh reset.
        do_reset();
        recv = 0; cyc = 0;
        out_ready = 1'b1; mode = 2'd3; a = '0;
        while (recv < 65537 && cyc < 70000) begin
            in_valid = (cyc < 65537);
            #1;
            if (out_valid && out_ready) recv++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        if (recv < 65537) check("wrap_timeout", LW'(recv), LW'(65537));
        #1;
        check("wrap_cnt", LW'(cnt), LW'(16'd1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
